mem_stream_ctrl: RTL and testbench
==================================

MEM_STREAM_CTRL -- requirements
Module: mem_stream_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream write word valid.
- in_ready  out  1  block accepts write word.
- in_data  in  32  write word.
- in_last  in  1  final word of write packet.
- rd_start  in  1  one-cycle read command pulse.
- rd_base  in  6  first read address.
- rd_len  in  7  words to read, 1..64.
- out_valid  out  1  read word valid.
- out_ready  in  1  downstream accepts read word.
- out_data  out  32  read word.
- out_last  out  1  final word of read burst.
- busy  out  1  state is not IDLE.
- wr_words  out  7  word count of last completed write packet, saturating at 64.
- mem_din  out  32  memory write data.
- mem_addr  out  6  memory address.
- mem_wen  out  1  memory write enable.
- mem_ren  out  1  memory read enable.
- mem_dout  in  32  memory read data; registered, valid the cycle after mem_ren, zero otherwise.

Function
REQ-002 The FSM SHALL have exactly three states: IDLE, WRITE and READ.
REQ-003 in_ready SHALL be 1 in IDLE and WRITE, and 0 in READ and during reset.
REQ-004 A write handshake is in_valid & in_ready. On each handshake the block SHALL drive mem_wen=1, mem_din=in_data and mem_addr=wr_ptr in the same cycle, then increment wr_ptr modulo 64.
REQ-005 The first handshake of a packet SHALL use address 0 and move IDLE->WRITE, unless in_last is also 1, in which case the state stays IDLE.
REQ-006 A handshake with in_last=1 SHALL:
- return the FSM to IDLE;
- reset wr_ptr to 0;
- load wr_words with the packet length, saturated at 64.
Packets longer than 64 words wrap and overwrite from address 0.
REQ-007 rd_start SHALL be honoured only in IDLE; it is ignored in WRITE and READ.
REQ-008 If rd_start and in_valid are both 1 in IDLE, rd_start SHALL win, and in_ready SHALL be 0 in that cycle.
REQ-009 When rd_start is honoured, the block SHALL latch rd_base and the effective length, then enter READ:
- rd_len=0: command ignored, FSM stays IDLE;
- rd_len>64: effective length clamped to 64.
REQ-010 In READ, the block SHALL issue mem_ren=1 with mem_addr=(rd_base+i) mod 64, for i = 0 .. len-1 in order.
REQ-011 A read SHALL be issued only when fifo_count + inflight < 2. inflight is 1 for the cycle after a mem_ren; fifo_count is the occupancy of the output FIFO (REQ-012).
REQ-012 mem_dout SHALL be pushed into a 2-entry output FIFO the cycle after each mem_ren, tagged with last = (i == len-1).
REQ-013 out_valid/out_data/out_last SHALL present the FIFO head; a word pops on out_valid & out_ready.
REQ-014 Minimum read latency SHALL be 2 cycles from the cycle mem_ren is issued to out_valid=1. With out_ready held at 1, the block SHALL deliver 1 word per cycle after the first.
REQ-015 Output words SHALL never be dropped or duplicated under any out_ready pattern.
REQ-016 The FSM SHALL return from READ to IDLE in the cycle after the out_last word is popped.
REQ-017 mem_wen and mem_ren SHALL never both be 1. When neither is 1, mem_addr and mem_din SHALL be 0.
REQ-018 busy SHALL be 1 exactly when the state is WRITE or READ.

Reset
REQ-019 reset is synchronous, active-high, on clk.
REQ-020 During and after reset the block SHALL hold:
- state IDLE;
- wr_ptr, wr_words and all read counters 0;
- FIFO empty, inflight 0;
- every output 0.
REQ-021 Reset asserted mid-WRITE or mid-READ SHALL abort the operation and discard in-flight memory data. Memory contents are not cleared.

Structure
REQ-022 A shared package mem_stream_pkg SHALL hold:
- the state enum (IDLE/WRITE/READ);
- ADDR_W=6, DATA_W=32, DEPTH=64, LEN_W=7.
REQ-023 The output buffer SHALL be a sub-module out_fifo2: 2 entries, DATA_W+1 bits wide, with valid/ready on both sides and a count output.
REQ-024 The block SHALL attach directly to one 64x32 memory whose reads have 1-cycle latency and whose read data is zero when not read.

Verification
REQ-025 Write packet 0x10,0x11,0x12 (in_last on the third word), then read rd_base=0, rd_len=3, out_ready=1:
- expect writes to addresses 0,1,2;
- wr_words=3;
- out_data 0x10,0x11,0x12 on consecutive cycles, out_last on 0x12;
- busy=0 afterwards.
REQ-026 Write a full 64-word ramp (0..63), then read rd_base=62, rd_len=4: expect addresses 62,63,0,1 and data 62,63,0,1.
REQ-027 Read 8 words with out_ready toggling 1,0,0,1 repeating: expect exactly 8 in-order words, never more than 2 reads outstanding plus buffered, and no mem_ren while the FIFO is full.
REQ-028 rd_start and in_valid together in IDLE: expect READ entered, in_ready=0, and no write that cycle. Also rd_len=0: expect IDLE held and no mem_ren.
REQ-029 Assert reset during the 3rd word of an 8-word read: next cycle expect out_valid=0, busy=0 and state IDLE. A new write then starts at address 0.
REQ-030 A 66-word write packet: expect wr_words=64, and addresses 0 and 1 holding words 64 and 65.

Source files
------------

// File: rtl/mem_stream_pkg.sv
// Shared types and sizes for the memory streaming controller.
package mem_stream_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned LEN_W  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  // Read word carried through the output FIFO.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } rd_word_t;

  // Word counter increment that sticks at DEPTH.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] n);
    return (n >= LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : n + LEN_W'(1);
  endfunction

endpackage

// File: rtl/out_fifo2.sv
// Two-entry valid/ready FIFO buffering memory read words toward the output.
module out_fifo2
  import mem_stream_pkg::*;
#(
  parameter int unsigned W = DATA_W + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] slot_q [2];
  logic         rd_ptr_q, wr_ptr_q;
  logic [1:0]   count_q;
  logic         push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = slot_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        slot_q[wr_ptr_q] <= in_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/mem_stream_ctrl.sv
// Streams write packets into a 64x32 memory and bursts reads back out
// through a 2-entry FIFO with credit-style read issue.
module mem_stream_ctrl
  import mem_stream_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [LEN_W-1:0]  wr_words,
  output logic [DATA_W-1:0] mem_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_dout
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]  wr_words_q, wr_words_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [LEN_W-1:0]  rd_len_q, rd_len_d;
  logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;

  logic              fifo_in_ready, fifo_out_valid;
  logic [DATA_W:0]   fifo_out_data;
  logic [1:0]        fifo_count;
  rd_word_t          head;
  logic              rd_cmd, rd_go, wr_hs, pop, issue;
  logic [2:0]        occ;

  out_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inflight_q),
    .in_ready  (fifo_in_ready),
    .in_data   ({infl_last_q, mem_dout}),
    .out_valid (fifo_out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out_data),
    .count     (fifo_count)
  );

  assign head = rd_word_t'(fifo_out_data);

  // Handshakes; a read command in IDLE takes priority over a write word.
  assign rd_cmd = (state_q == IDLE) & rd_start;
  assign rd_go  = rd_cmd & (rd_len != '0);
  assign pop    = fifo_out_valid & out_ready;
  assign wr_hs  = in_valid & in_ready;

  // Words buffered plus in flight, net of a same-cycle pop, must stay below 2.
  assign occ   = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign issue = !reset && (state_q == READ) && (rd_idx_q < rd_len_q)
                 && fifo_in_ready && (occ < 3'd2);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_cnt_d    = wr_cnt_q;
    wr_words_d  = wr_words_q;
    rd_base_d   = rd_base_q;
    rd_len_d    = rd_len_q;
    rd_idx_d    = rd_idx_q;
    inflight_d  = issue;
    infl_last_d = issue && (rd_idx_q == rd_len_q - LEN_W'(1));
    in_ready    = !reset && (state_q != READ) && !rd_cmd;

    if (wr_hs) begin
      if (in_last) begin
        wr_ptr_d   = '0;
        wr_cnt_d   = '0;
        wr_words_d = sat_inc(wr_cnt_q);
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        wr_cnt_d = sat_inc(wr_cnt_q);
      end
    end

    if (issue) rd_idx_d = rd_idx_q + LEN_W'(1);

    unique case (state_q)
      IDLE: begin
        if (rd_go) begin
          state_d   = READ;
          rd_base_d = rd_base;
          rd_len_d  = (rd_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : rd_len;
          rd_idx_d  = '0;
        end else if (wr_hs && !in_last) begin
          state_d = WRITE;
        end
      end
      WRITE: if (wr_hs && in_last) state_d = IDLE;
      READ:  if (pop && head.last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      wr_cnt_q    <= '0;
      wr_words_q  <= '0;
      rd_base_q   <= '0;
      rd_len_q    <= '0;
      rd_idx_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_words_q  <= wr_words_d;
      rd_base_q   <= rd_base_d;
      rd_len_q    <= rd_len_d;
      rd_idx_q    <= rd_idx_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
    end
  end

  // Memory port: zeroed whenever neither write nor read is active.
  assign mem_wen  = wr_hs;
  assign mem_ren  = issue;
  assign mem_din  = wr_hs ? in_data : '0;
  assign mem_addr = wr_hs ? wr_ptr_q
                  : issue ? rd_base_q + ADDR_W'(rd_idx_q)
                  : '0;

  assign out_valid = !reset && fifo_out_valid;
  assign out_data  = out_valid ? head.data : '0;
  assign out_last  = out_valid && head.last;
  assign busy      = !reset && (state_q != IDLE);
  assign wr_words  = reset ? '0 : wr_words_q;

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// Directed self-checking bench for mem_stream_ctrl with a 1-cycle-latency memory model.
module tb_mem_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        rd_start;
  logic [5:0]  rd_base;
  logic [6:0]  rd_len;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        busy;
  logic [6:0]  wr_words;
  logic [31:0] mem_din;
  logic [5:0]  mem_addr;
  logic        mem_wen, mem_ren;
  logic [31:0] mem_dout = '0;

  int n_assert = 0;
  int n_fail   = 0;

  mem_stream_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .wr_words(wr_words),
    .mem_din(mem_din), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // 64x32 memory, read data registered and zero when not read
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_din;
    mem_dout <= mem_ren ? mem[mem_addr] : 32'h0;
  end

  // Monitor: logs memory and output traffic, tracks protocol violations
  int          cyc = 0;
  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [5:0]  ra_q[$];
  int          rc_q[$];
  logic [31:0] od_q[$];
  logic        ol_q[$];
  int          oc_q[$];
  int          n_ren = 0, n_pop = 0;
  int          viol_both = 0, viol_outst = 0, viol_idle = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      n_ren = 0;
      n_pop = 0;
    end else begin
      if (mem_wen) begin wa_q.push_back(mem_addr); wd_q.push_back(mem_din); end
      if (mem_ren) begin
        ra_q.push_back(mem_addr);
        rc_q.push_back(cyc);
        if ((n_ren - n_pop - ((out_valid && out_ready) ? 1 : 0)) > 1) viol_outst++;
        n_ren++;
      end
      if (mem_wen && mem_ren) viol_both++;
      if (!mem_wen && !mem_ren && (mem_addr != 6'd0 || mem_din != 32'd0)) viol_idle++;
      if (out_valid && out_ready) begin
        od_q.push_back(out_data);
        ol_q.push_back(out_last);
        oc_q.push_back(cyc);
        n_pop++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input int n, input logic [31:0] start);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = start + 32'(i);
      in_last  = (i == n - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [5:0] base, input logic [6:0] len,
                         input bit toggle);
    bit done = 1'b0;
    rd_base   = base;
    rd_len    = len;
    rd_start  = 1'b1;
    out_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int k = 1; k < 600; k++) begin
      out_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      tick();
      if (!busy) begin done = 1'b1; break; end
    end
    out_ready = 1'b1;
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int wb, rb, ob, lasts;
    bit hit;
    reset = 1'b1; in_valid = 0; in_data = 0; in_last = 0;
    rd_start = 0; rd_base = 0; rd_len = 0; out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_mem_en", 32'({mem_wen, mem_ren}), 0);
    chk("rst_wr_words", 32'(wr_words), 0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 1);

    // 3-word packet then read it back
    wb = wa_q.size();
    send_packet(3, 32'h10);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("p3_waddr%0d", i), 32'(wa_q[wb+i]), 32'(i));
      chk($sformatf("p3_wdata%0d", i), wd_q[wb+i], 32'h10 + 32'(i));
    end
    chk("p3_wr_words", 32'(wr_words), 3);
    chk("p3_busy", 32'(busy), 0);
    rb = ra_q.size(); ob = od_q.size();
    do_read("r3", 6'd0, 7'd3, 1'b0);
    chk("r3_count", 32'(od_q.size() - ob), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("r3_data%0d", i), od_q[ob+i], 32'h10 + 32'(i));
      chk($sformatf("r3_last%0d", i), 32'(ol_q[ob+i]), 32'(i == 2));
    end
    chk("r3_latency", 32'(oc_q[ob] - rc_q[rb]), 2);
    chk("r3_back2back", 32'(oc_q[ob+2] - oc_q[ob]), 2);
    chk("r3_busy_after", 32'(busy), 0);

    // 64-word ramp, wrapped read 62..1
    send_packet(64, 32'd0);
    chk("ramp_wr_words", 32'(wr_words), 64);
    rb = ra_q.size(); ob = od_q.size();
    do_read("r62", 6'd62, 7'd4, 1'b0);
    chk("r62_count", 32'(od_q.size() - ob), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("r62_addr%0d", i), 32'(ra_q[rb+i]), 32'((62 + i) % 64));
      chk($sformatf("r62_data%0d", i), od_q[ob+i], 32'((62 + i) % 64));
    end

    // 8 words under a 1,0,0,1 out_ready pattern
    ob = od_q.size();
    do_read("r8t", 6'd0, 7'd8, 1'b1);
    chk("r8t_count", 32'(od_q.size() - ob), 8);
    lasts = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("r8t_data%0d", i), od_q[ob+i], 32'(i));
      if (ol_q[ob+i]) lasts++;
    end
    chk("r8t_last_flag", 32'(ol_q[ob+7]), 1);
    chk("r8t_lasts", 32'(lasts), 1);

    // rd_start collides with a write word in IDLE
    wb = wa_q.size(); ob = od_q.size();
    rd_base = 6'd5; rd_len = 7'd2; rd_start = 1'b1;
    in_valid = 1'b1; in_data = 32'hDEAD; in_last = 1'b1;
    @(negedge clk);
    chk("coll_in_ready", 32'(in_ready), 0);
    chk("coll_mem_wen", 32'(mem_wen), 0);
    tick();
    rd_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("coll_busy", 32'(busy), 1);
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (!busy) begin hit = 1'b1; break; end
    end
    chk("coll_done", 32'(hit), 1);
    chk("coll_no_write", 32'(wa_q.size() - wb), 0);
    chk("coll_count", 32'(od_q.size() - ob), 2);
    chk("coll_data0", od_q[ob], 32'd5);
    chk("coll_data1", od_q[ob+1], 32'd6);

    // zero-length read is ignored
    rb = ra_q.size();
    rd_base = 6'd3; rd_len = 7'd0; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("len0_busy", 32'(busy), 0);
    tick(); tick(); tick();
    chk("len0_no_ren", 32'(ra_q.size() - rb), 0);

    // rd_len above 64 is clamped
    ob = od_q.size();
    do_read("r100", 6'd0, 7'd100, 1'b0);
    chk("r100_count", 32'(od_q.size() - ob), 64);
    chk("r100_last_data", od_q[od_q.size()-1], 32'd63);
    chk("r100_last_flag", 32'(ol_q[ol_q.size()-1]), 1);

    // reset while the third word of an 8-word read is presented
    ob = od_q.size();
    rd_base = 6'd0; rd_len = 7'd8; rd_start = 1'b1; out_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (od_q.size() - ob == 2) begin hit = 1'b1; break; end
    end
    chk("rstmid_reached", 32'(hit), 1);
    chk("rstmid_third_valid", 32'(out_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_out_valid", 32'(out_valid), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_idle", 32'(in_ready), 1);
    ob = od_q.size();
    tick(); tick(); tick();
    chk("rstmid_no_pop", 32'(od_q.size() - ob), 0);
    wb = wa_q.size();
    send_packet(2, 32'hA0);
    chk("rstmid_waddr0", 32'(wa_q[wb]), 0);
    chk("rstmid_waddr1", 32'(wa_q[wb+1]), 1);

    // 66-word packet wraps and saturates the count
    wb = wa_q.size();
    send_packet(66, 32'd0);
    chk("p66_wr_words", 32'(wr_words), 64);
    chk("p66_waddr64", 32'(wa_q[wb+64]), 0);
    chk("p66_waddr65", 32'(wa_q[wb+65]), 1);
    ob = od_q.size();
    do_read("r66", 6'd0, 7'd2, 1'b0);
    chk("r66_data0", od_q[ob], 32'd64);
    chk("r66_data1", od_q[ob+1], 32'd65);

    chk("never_wen_and_ren", 32'(viol_both), 0);
    chk("outstanding_le_2", 32'(viol_outst), 0);
    chk("idle_addr_din_zero", 32'(viol_idle), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
